// File: rtl/win_pkg.sv
// Shared definitions for the range-window stage and its frame sequencer:
// legal chirp modes, window-ROM base table, per-mode sample limits, FSM states.
package win_pkg;

  localparam int unsigned MAX_SMP   = 4096;
  localparam int unsigned ROM_DEPTH = 8192;
  localparam int unsigned CFG_W     = 16;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned SMP_CNT_W = 13;
  localparam int unsigned DATA_W    = 32;

  localparam logic [CFG_W-1:0] CHIRP_32  = 16'd32;
  localparam logic [CFG_W-1:0] CHIRP_64  = 16'd64;
  localparam logic [CFG_W-1:0] CHIRP_128 = 16'd128;

  localparam logic [ADDR_W-1:0] BASE_128 = 13'd0;
  localparam logic [ADDR_W-1:0] BASE_64  = 13'd5120;
  localparam logic [ADDR_W-1:0] BASE_32  = 13'd1024;

  localparam logic [CFG_W-1:0] LIMIT_128 = 16'd1024;
  localparam logic [CFG_W-1:0] LIMIT_64  = 16'd3072;
  localparam logic [CFG_W-1:0] LIMIT_32  = 16'd4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] base;
  } cfg_chk_t;

  // Validate a frame config and return the window-ROM base for its chirp mode.
  function automatic cfg_chk_t cfg_check(input logic [CFG_W-1:0] chirp_num,
                                         input logic [CFG_W-1:0] sample_num);
    cfg_chk_t         r;
    logic [CFG_W-1:0] limit;
    r.ok   = 1'b0;
    r.base = '0;
    limit  = '0;
    case (chirp_num)
      CHIRP_128: begin r.ok = 1'b1; r.base = BASE_128; limit = LIMIT_128; end
      CHIRP_64:  begin r.ok = 1'b1; r.base = BASE_64;  limit = LIMIT_64;  end
      CHIRP_32:  begin r.ok = 1'b1; r.base = BASE_32;  limit = LIMIT_32;  end
      default:   r.ok = 1'b0;
    endcase
    if (sample_num == '0 || sample_num > limit || 32'(sample_num) > MAX_SMP)
      r.ok = 1'b0;
    if (32'(r.base) + 32'(sample_num) > ROM_DEPTH)
      r.ok = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/win_r_seq_if.sv
// Raw ADC beat input and framed beat output toward the window stage.
interface win_r_seq_if;
  import win_pkg::*;

  logic              adc_in_valid;
  logic [DATA_W-1:0] adc_in_data;
  logic              adc_data_valid;
  logic [DATA_W-1:0] adc_data;
  logic              adc_data_sop;
  logic              adc_data_eop;

  modport slave (
    input  adc_in_valid, adc_in_data,
    output adc_data_valid, adc_data, adc_data_sop, adc_data_eop
  );

  modport master (
    output adc_in_valid, adc_in_data,
    input  adc_data_valid, adc_data, adc_data_sop, adc_data_eop
  );
endinterface

// File: rtl/win_r_seq.sv
// Frame/chirp sequencer: validates and latches the frame config, cuts the raw
// ADC stream into chirp packets with sop/eop, and reports frame status.
module win_r_seq
  import win_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [CFG_W-1:0]  cfg_sample_num,
  input  logic [CFG_W-1:0]  cfg_chirp_num,
  input  logic [CFG_W-1:0]  cfg_adc_truncation,
  win_r_seq_if.slave        adc,
  output logic [CFG_W-1:0]  sample_num,
  output logic [CFG_W-1:0]  chirp_num,
  output logic [CFG_W-1:0]  adc_truncation,
  output logic [ADDR_W-1:0] win_base_addr,
  output logic [CFG_W-1:0]  chirp_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  state_t                 state_q, state_d;
  logic [SMP_CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [CFG_W-1:0]       sample_num_d, chirp_num_d, adc_truncation_d, chirp_idx_d;
  logic [ADDR_W-1:0]      win_base_addr_d;
  logic                   busy_d, frame_done_d, cfg_err_d;
  logic                   valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_W-1:0]      data_q, data_d;
  cfg_chk_t               chk;
  logic                   last_smp, last_chirp;

  assign adc.adc_data_valid = valid_q;
  assign adc.adc_data       = data_q;
  assign adc.adc_data_sop   = sop_q;
  assign adc.adc_data_eop   = eop_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      smp_cnt_q      <= '0;
      sample_num     <= '0;
      chirp_num      <= '0;
      adc_truncation <= '0;
      win_base_addr  <= '0;
      chirp_idx      <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      cfg_err        <= 1'b0;
      valid_q        <= 1'b0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      smp_cnt_q      <= smp_cnt_d;
      sample_num     <= sample_num_d;
      chirp_num      <= chirp_num_d;
      adc_truncation <= adc_truncation_d;
      win_base_addr  <= win_base_addr_d;
      chirp_idx      <= chirp_idx_d;
      busy           <= busy_d;
      frame_done     <= frame_done_d;
      cfg_err        <= cfg_err_d;
      valid_q        <= valid_d;
      sop_q          <= sop_d;
      eop_q          <= eop_d;
      data_q         <= data_d;
    end
  end

  // Next-state and next-output logic; abort overrides every state.
  always_comb begin
    state_d          = state_q;
    smp_cnt_d        = smp_cnt_q;
    sample_num_d     = sample_num;
    chirp_num_d      = chirp_num;
    adc_truncation_d = adc_truncation;
    win_base_addr_d  = win_base_addr;
    chirp_idx_d      = chirp_idx;
    busy_d           = busy;
    frame_done_d     = 1'b0;
    cfg_err_d        = 1'b0;
    valid_d          = 1'b0;
    sop_d            = 1'b0;
    eop_d            = 1'b0;
    data_d           = data_q;
    chk              = cfg_check(cfg_chirp_num, cfg_sample_num);
    last_smp         = (CFG_W'(smp_cnt_q) == sample_num - 16'd1);
    last_chirp       = (chirp_idx == chirp_num - 16'd1);

    if (abort) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      smp_cnt_d   = '0;
      chirp_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            if (chk.ok) begin
              sample_num_d     = cfg_sample_num;
              chirp_num_d      = cfg_chirp_num;
              adc_truncation_d = cfg_adc_truncation;
              win_base_addr_d  = chk.base;
              busy_d           = 1'b1;
              chirp_idx_d      = '0;
              smp_cnt_d        = '0;
              state_d          = ST_RUN;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (adc.adc_in_valid) begin
            valid_d = 1'b1;
            data_d  = adc.adc_in_data;
            sop_d   = (smp_cnt_q == '0);
            eop_d   = last_smp;
            if (last_smp) begin
              smp_cnt_d = '0;
              // The final chirp index is held until the next accepted frame.
              if (last_chirp) state_d = ST_DONE;
              else            chirp_idx_d = chirp_idx + 16'd1;
            end else begin
              smp_cnt_d = SMP_CNT_W'(smp_cnt_q + 13'd1);
            end
          end
        end
        ST_DONE: begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/win_r_seq.md
Name: win_r_seq

Overview:
- Frame/chirp sequencer placed in front of the range-window stage (win_r).
- Accepts a raw, un-framed ADC beat stream and a frame_start command.
- Latches and validates the per-frame config, cuts the stream into chirp packets with sop/eop, and drives the window stage with stable sample_num, chirp_num, window-ROM base and adc_truncation.
- Reports busy, frame_done and config errors to the control plane.

Parameters:
- MAX_SMP, 4096: absolute upper bound on sample_num.
- ROM_DEPTH, 8192: window ROM depth in words; base + sample_num must not exceed it.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  single-cycle frame start command
- abort  in  1  single-cycle abort; returns to IDLE
- cfg_sample_num  in  16  samples per chirp
- cfg_chirp_num  in  16  chirps per frame; legal values 32, 64, 128
- cfg_adc_truncation  in  16  truncation shift for the window output
- adc_in_valid  in  1  raw beat valid
- adc_in_data  in  32  raw beat {im[31:16], re[15:0]}
- adc_data_valid  out  1  framed beat valid
- adc_data  out  32  framed beat
- adc_data_sop  out  1  first sample of a chirp
- adc_data_eop  out  1  last sample of a chirp
- sample_num  out  16  latched sample count
- chirp_num  out  16  latched chirp count
- adc_truncation  out  16  latched truncation
- win_base_addr  out  13  window-ROM base for the latched chirp_num
- chirp_idx  out  16  index of the current chirp, 0-based
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last eop
- cfg_err  out  1  one-cycle pulse when a frame_start is rejected

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0; state is IDLE; counters are 0.
- States: IDLE, RUN, DONE.
- IDLE, on frame_start, validates the config:
  - chirp_num must be 32, 64 or 128.
  - sample_num must satisfy 1 <= sample_num <= limit, where the limit is 1024 for 128 chirps, 3072 for 64 and 4096 for 32.
  - Illegal config: pulse cfg_err the next cycle and stay in IDLE; latched outputs keep their previous values.
  - Legal config: latch sample_num, chirp_num and adc_truncation; set win_base_addr (128 -> 0, 64 -> 5120, 32 -> 1024); busy=1; chirp_idx=0; smp_cnt=0; go to RUN.
- Latched config outputs are stable from the cycle after acceptance until the next accepted frame_start. They do not change at frame end.
- RUN:
  - Each adc_in_valid beat is registered to the outputs with 1-cycle latency: adc_data_valid=1, adc_data=adc_in_data.
  - adc_data_sop=1 when smp_cnt==0.
  - adc_data_eop=1 when smp_cnt==sample_num-1; smp_cnt then wraps to 0 and chirp_idx increments.
  - sample_num==1 gives sop and eop on the same beat.
  - Gaps in adc_in_valid are allowed anywhere. Outputs hold valid/sop/eop at 0 during gaps; counters are unchanged.
  - An eop when chirp_idx==chirp_num-1 moves to DONE.
- DONE: frame_done=1 for exactly one cycle, coincident with busy falling to 0; then IDLE.
  - frame_done follows the last eop by 1 cycle.
  - chirp_idx holds chirp_num-1 until the next accepted frame_start.
- adc_in_valid outside RUN is dropped: no output beat.
- frame_start while busy is ignored, with no cfg_err.
- abort is effective in any state next cycle:
  - Go to IDLE, busy=0, counters cleared.
  - No eop and no frame_done are generated.
  - Any beat arriving in the abort cycle is dropped.
  - abort wins over a simultaneous frame_start or last eop.
- frame_start and the first adc_in_valid in the same cycle: that beat is dropped; sampling starts the following cycle.
- Counters: smp_cnt is 13 bits, chirp_idx is 16 bits. There is no overflow by construction because of the config checks.

Decomposition:
- Shared package win_pkg: legal chirp_num constants (32, 64, 128), window-ROM base constants (0, 1024, 5120), per-mode sample limits, and the state enum.
- No sub-module. The config checker is a small function in win_pkg so that win_r and win_r_seq share the same base-address table.

Test Plan:
1. Reset then a legal frame (chirp_num=32, sample_num=4, trunc=3), continuous valid -> win_base_addr=1024, adc_truncation=3. 32 chirps, each with sop on beat 0 and eop on beat 3. frame_done 1 cycle after the 128th beat; busy high 129+ cycles.
2. frame_start with chirp_num=48, then with chirp_num=128 and sample_num=2048 -> cfg_err pulses twice, busy stays 0, no output beats.
3. chirp_num=64, sample_num=1, adc_in_valid toggling 1010... -> 64 beats, each with sop=eop=1; win_base_addr=5120; output valid only one cycle after each input valid.
4. abort mid-chirp (chirp_idx=5, smp_cnt=2) -> no eop, no frame_done, busy=0 next cycle. A new frame_start is then accepted with chirp_idx=0.
5. frame_start asserted during RUN, and adc_in_valid in IDLE -> both ignored; frame completes with the originally latched config.
6. rst_n low mid-frame for 1 cycle -> all outputs 0 next cycle; state IDLE.
